lfsr_checker: RTL and testbench



---
 rtl/lfsr_checker.sv | 223 ++++++++++++++++++++++
 tb/tb_lfsr_checker.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// lfsr_checker
// Serial PRBS checker for an XNOR-feedback LFSR bit stream. It hunts for
// sync by predicting each incoming bit from the last NUM_BITS received bits.
// After LOCK_CNT consecutive correct predictions it declares lock and then
// free-runs its own copy of the generator. In that state every received bit
// that disagrees with the prediction is reported as a bit error. Too many
// errors inside one WINDOW drops it back to hunting.
`timescale 1ns/1ps

module lfsr_checker #(
    parameter int NUM_BITS   = 32,
    parameter int LOCK_CNT   = 64,
    parameter int WINDOW     = 256,
    parameter int UNLOCK_ERR = 16,
    parameter int CNT_W      = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             E,
    input  logic             DIN,
    input  logic             CLR_CNT,
    output logic             LOCKED,
    output logic             ERR,
    output logic [CNT_W-1:0] ERR_CNT
);

    // ------------------------------------------------------------------
    // Counter widths: each counter must be able to hold its terminal value
    // ------------------------------------------------------------------
    localparam int FILL_W  = $clog2(NUM_BITS + 1);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W   = $clog2(WINDOW + 1);
    localparam int WERR_W  = $clog2(UNLOCK_ERR + 1);

    // Tap positions as a bit mask over the history, H1 at bit 0.
    //   8 : H8  H6  H5 H4 -> 0xB8
    //   16: H16 H15 H13 H4 -> 0xD008
    //   32: H32 H22 H2 H1  -> 0x80200003
    localparam logic [31:0] TAP_MASK32 =
        (NUM_BITS == 8)  ? 32'h0000_00B8 :
        (NUM_BITS == 16) ? 32'h0000_D008 :
                           32'h8020_0003;
    localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_MASK32[NUM_BITS-1:0];

    // ------------------------------------------------------------------
    // Parameter sanity: only the three tabulated polynomials exist
    // ------------------------------------------------------------------
    generate
        if (NUM_BITS != 8 && NUM_BITS != 16 && NUM_BITS != 32) begin : g_bad_len
            $error("lfsr_checker: NUM_BITS must be 8, 16 or 32");
        end
        if (LOCK_CNT < 1 || WINDOW < 1 || UNLOCK_ERR < 1 || CNT_W < 1) begin : g_bad_cnt
            $error("lfsr_checker: LOCK_CNT, WINDOW, UNLOCK_ERR and CNT_W must be positive");
        end
    endgenerate

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                state_reg,   state_next;
    logic [NUM_BITS-1:0]   h_reg,       h_next;
    logic [FILL_W-1:0]     fill_reg,    fill_next;
    logic [MATCH_W-1:0]    match_reg,   match_next;
    logic [WIN_W-1:0]      win_reg,     win_next;
    logic [WERR_W-1:0]     werr_reg,    werr_next;
    logic                  locked_reg,  locked_next;
    logic                  err_reg,     err_next;
    logic [CNT_W-1:0]      err_cnt_reg, err_cnt_next;

    // ------------------------------------------------------------------
    // Prediction
    // ------------------------------------------------------------------
    logic [NUM_BITS-1:0] tapped;
    logic                pred;
    logic                pred_err;
    logic                hist_all_ones;
    logic                fill_done;
    logic [MATCH_W-1:0]  match_inc;
    logic [WIN_W-1:0]    win_inc;
    logic [WERR_W-1:0]   werr_inc;
    logic                lock_err;

    // Keep only the tapped history bits; everything else contributes 0.
    generate
        for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_tap
            assign tapped[gi] = TAP_MASK[gi] ? h_reg[gi] : 1'b0;
        end
    endgenerate

    // Four tapped bits, three of them inverted: an odd number of
    // inversions folds into a single inversion of the plain parity.
    assign pred          = ~(^tapped);
    assign pred_err      = (DIN != pred);
    assign hist_all_ones = &h_reg;
    assign fill_done     = (fill_reg >= FILL_W'(NUM_BITS));

    // Error on a bit is only meaningful while locked and consuming a bit.
    assign lock_err  = E && (state_reg == ST_LOCKED) && pred_err;

    assign match_inc = match_reg + MATCH_W'(1);
    assign win_inc   = win_reg + WIN_W'(1);
    assign werr_inc  = werr_reg + WERR_W'(lock_err);

    // ------------------------------------------------------------------
    // FSM state register (asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_HUNT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state plus history and sync/window counters.
    always_comb begin
        state_next = state_reg;
        h_next     = h_reg;
        fill_next  = fill_reg;
        match_next = match_reg;
        win_next   = win_reg;
        werr_next  = werr_reg;

        if (E) begin
            case (state_reg)
                ST_HUNT: begin
                    // While hunting the history tracks the received bits.
                    h_next = {h_reg[NUM_BITS-2:0], DIN};
                    if (!fill_done) begin
                        // History not yet fully populated: no prediction.
                        fill_next = fill_reg + FILL_W'(1);
                    end else if (pred_err || hist_all_ones) begin
                        // All-ones is the XNOR lock-up state; never trust it.
                        match_next = '0;
                    end else if (match_inc == MATCH_W'(LOCK_CNT)) begin
                        state_next = ST_LOCKED;
                        match_next = '0;
                        win_next   = '0;
                        werr_next  = '0;
                    end else begin
                        match_next = match_inc;
                    end
                end

                ST_LOCKED: begin
                    // Free-run on our own prediction so a line error is
                    // never fed back into the history.
                    h_next = {h_reg[NUM_BITS-2:0], pred};
                    if (werr_inc == WERR_W'(UNLOCK_ERR)) begin
                        state_next = ST_HUNT;
                        fill_next  = '0;
                        match_next = '0;
                        win_next   = '0;
                        werr_next  = '0;
                    end else if (win_inc == WIN_W'(WINDOW)) begin
                        win_next  = '0;
                        werr_next = '0;
                    end else begin
                        win_next  = win_inc;
                        werr_next = werr_inc;
                    end
                end

                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

    // Next values of the registered outputs.
    always_comb begin
        locked_next  = (state_next == ST_LOCKED);
        err_next     = lock_err;
        err_cnt_next = err_cnt_reg;
        if (CLR_CNT) begin
            // A clear that coincides with an error keeps that one error.
            err_cnt_next = lock_err ? CNT_W'(1) : '0;
        end else if (lock_err && !(&err_cnt_reg)) begin
            err_cnt_next = err_cnt_reg + CNT_W'(1);
        end
    end

    // Datapath registers: history and counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_reg     <= '0;
            fill_reg  <= '0;
            match_reg <= '0;
            win_reg   <= '0;
            werr_reg  <= '0;
        end else begin
            h_reg     <= h_next;
            fill_reg  <= fill_next;
            match_reg <= match_next;
            win_reg   <= win_next;
            werr_reg  <= werr_next;
        end
    end

    // Output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            locked_reg  <= 1'b0;
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            locked_reg  <= locked_next;
            err_reg     <= err_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign LOCKED  = locked_reg;
    assign ERR     = err_reg;
    assign ERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_lfsr_checker.sv
// Testbench for lfsr_checker: directed streams from a 32-bit XNOR generator,
// a behavioural reference model, and a per-cycle compare of two instances
// (default counter width and a 4-bit counter).
`timescale 1ns/1ps

module tb_lfsr_checker;

    localparam int NB    = 32;
    localparam int LOCKN = 64;
    localparam int WIN   = 256;
    localparam int UNL   = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        e   = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err, locked4, err4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    lfsr_checker dut (
        .CLK(clk), .RESET(rst), .E(e), .DIN(din), .CLR_CNT(clr),
        .LOCKED(locked), .ERR(err), .ERR_CNT(cnt)
    );

    lfsr_checker #(.CNT_W(4)) dut4 (
        .CLK(clk), .RESET(rst), .E(e), .DIN(din), .CLR_CNT(clr),
        .LOCKED(locked4), .ERR(err4), .ERR_CNT(cnt4)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_hist[1:NB];
    bit g_hist[1:NB];
    bit m_locked;
    int m_fill, m_match, m_win, m_werr;
    bit exp_err;
    int exp_cnt16, exp_cnt4;
    int cur_bit;
    bit cmp_en = 1'b0;

    // event tracking (from DUT outputs)
    int lock_rises, lock_falls, lock_rise_bit, lock_fall_bit;
    int err_pulses, err_bit;
    bit prev_locked;

    function void model_reset();
        for (int i = 1; i <= NB; i++) begin
            m_hist[i] = 1'b0;
            g_hist[i] = 1'b0;
        end
        m_locked = 1'b0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        exp_err = 1'b0; exp_cnt16 = 0; exp_cnt4 = 0; cur_bit = 0;
        lock_rises = 0; lock_falls = 0; lock_rise_bit = -1; lock_fall_bit = -1;
        err_pulses = 0; err_bit = -1; prev_locked = 1'b0;
    endfunction

    // Generator: next bit of the 32-bit XNOR sequence seeded with zeros.
    function bit gen_bit();
        bit b;
        b = g_hist[32] ^ !g_hist[22] ^ !g_hist[2] ^ !g_hist[1];
        for (int i = NB; i >= 2; i--) g_hist[i] = g_hist[i-1];
        g_hist[1] = b;
        return b;
    endfunction

    function void model_shift(input bit b);
        for (int i = NB; i >= 2; i--) m_hist[i] = m_hist[i-1];
        m_hist[1] = b;
    endfunction

    function void model_step(input bit te, input bit td, input bit tc);
        bit p;
        bit ones;
        exp_err = 1'b0;
        if (te) begin
            p = m_hist[32] ^ !m_hist[22] ^ !m_hist[2] ^ !m_hist[1];
            ones = 1'b1;
            for (int i = 1; i <= NB; i++) if (!m_hist[i]) ones = 1'b0;
            if (!m_locked) begin
                model_shift(td);
                if (m_fill < NB) m_fill++;
                else begin
                    if (td == p && !ones) m_match++;
                    else m_match = 0;
                    if (m_match == LOCKN) begin
                        m_locked = 1'b1; m_match = 0; m_win = 0; m_werr = 0;
                    end
                end
            end else begin
                model_shift(p);
                m_win++;
                if (td != p) begin
                    exp_err = 1'b1;
                    m_werr++;
                end
                if (m_werr == UNL) begin
                    m_locked = 1'b0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WIN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (tc) begin
            exp_cnt16 = exp_err ? 1 : 0;
            exp_cnt4  = exp_err ? 1 : 0;
        end else if (exp_err) begin
            if (exp_cnt16 < 65535) exp_cnt16++;
            if (exp_cnt4 < 15) exp_cnt4++;
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit te, input bit td, input bit tc);
        @(negedge clk);
        e = te; din = td; clr = tc;
        if (te) cur_bit++;
        model_step(te, td, tc);
        @(posedge clk);
        #2;
    endtask

    task automatic send(input bit flip, input bit tc, output bit b);
        b = gen_bit();
        step(1'b1, b ^ flip, tc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; e = 1'b0; din = 1'b0; clr = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- per-cycle compare ----------------
    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("locked",     locked,  m_locked);
            chk("err",        err,     exp_err);
            chk("err_cnt",    cnt,     exp_cnt16);
            chk("locked_w4",  locked4, m_locked);
            chk("err_w4",     err4,    exp_err);
            chk("err_cnt_w4", cnt4,    exp_cnt4);
            if (locked && !prev_locked) begin lock_rises++; lock_rise_bit = cur_bit; end
            if (!locked && prev_locked) begin lock_falls++; lock_fall_bit = cur_bit; end
            if (err) begin err_pulses++; err_bit = cur_bit; end
            prev_locked = locked;
        end
    end

    // ---------------- directed tests ----------------
    initial begin
        bit b;
        bit [5:0] first6;
        int cyc;

        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        cmp_en = 1'b1;

        // Reset state
        chk("reset_locked", locked, 0);
        chk("reset_err", err, 0);
        chk("reset_cnt", cnt, 0);
        $display("test reset state done");

        // Clean stream, 1000 bits
        first6 = '0;
        for (int i = 1; i <= 1000; i++) begin
            send(1'b0, 1'b0, b);
            if (i <= 6) first6 = {first6[4:0], b};
        end
        chk("gen_first6", first6, 6'b100100);
        chk("clean_lock_bit", lock_rise_bit, 96);
        chk("clean_lock_rises", lock_rises, 1);
        chk("clean_err_pulses", err_pulses, 0);
        chk("clean_cnt", cnt, 0);
        chk("clean_locked_end", locked, 1);
        $display("test clean stream done");

        // Single error at bit 300
        do_reset();
        for (int i = 1; i <= 400; i++) send(i == 300, 1'b0, b);
        chk("single_pulses", err_pulses, 1);
        chk("single_err_bit", err_bit, 300);
        chk("single_cnt", cnt, 1);
        chk("single_falls", lock_falls, 0);
        chk("single_locked", locked, 1);
        $display("test single error done");

        // 15 errors in one window: stays locked
        do_reset();
        for (int i = 1; i <= 400; i++) send(i >= 110 && i <= 250 && i % 10 == 0, 1'b0, b);
        chk("dens15_cnt", cnt, 15);
        chk("dens15_falls", lock_falls, 0);
        chk("dens15_locked", locked, 1);
        $display("test 15 errors done");

        // 16 errors in one window: unlock on the 16th, relock 96 bits later
        do_reset();
        for (int i = 1; i <= 400; i++) send(i >= 110 && i <= 260 && i % 10 == 0, 1'b0, b);
        chk("dens16_fall_bit", lock_fall_bit, 260);
        chk("dens16_relock_bit", lock_rise_bit, 356);
        chk("dens16_rises", lock_rises, 2);
        chk("dens16_cnt", cnt, 16);
        chk("dens16_cnt_w4", cnt4, 15);
        $display("test 16 errors done");

        // Lock-up guard: all-ones input
        do_reset();
        for (int i = 1; i <= 500; i++) step(1'b1, 1'b1, 1'b0);
        chk("lockup_rises", lock_rises, 0);
        chk("lockup_locked", locked, 0);
        $display("test lock-up guard done");

        // Counter saturation: 20 errors, one per window
        do_reset();
        for (int i = 1; i <= 5000; i++)
            send(i >= 107 && i <= 4971 && (i - 107) % 256 == 0, 1'b0, b);
        chk("sat_cnt_w4", cnt4, 15);
        chk("sat_cnt", cnt, 20);
        chk("sat_falls", lock_falls, 0);
        send(1'b1, 1'b1, b);
        chk("clr_with_err_cnt", cnt, 1);
        chk("clr_with_err_cnt_w4", cnt4, 1);
        chk("clr_with_err_pulse", err, 1);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_alone_cnt", cnt, 0);
        chk("clr_alone_cnt_w4", cnt4, 0);
        $display("test counter control done");

        // Random enable at ~50% duty
        do_reset();
        cyc = 0;
        while (cur_bit < 300 && cyc < 5000) begin
            if ($urandom_range(0, 1) == 1) send(cur_bit + 1 == 250, 1'b0, b);
            else step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            cyc++;
        end
        chk("rand_bits_reached", cur_bit, 300);
        chk("rand_lock_bit", lock_rise_bit, 96);
        chk("rand_err_bit", err_bit, 250);
        chk("rand_cnt", cnt, 1);
        $display("test random enable done");

        // Asynchronous reset between edges while locked
        chk("pre_reset_locked", locked, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_locked", locked, 0);
        chk("async_cnt", cnt, 0);
        chk("async_cnt_w4", cnt4, 0);
        model_reset();
        e = 1'b0; clr = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        $display("test async reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
